// File: rtl/leaf_tx_pkg.sv
// Shared constants and types for the leaf transmit scheduler.
// Packet layout: {valid, leaf, port, seq, payload}, with the payload in the low bits.
package leaf_tx_pkg;

  localparam int unsigned DEF_NUM_OUT_PORTS = 2;
  localparam int unsigned DEF_PAYLOAD_BITS  = 32;
  localparam int unsigned DEF_PACKET_BITS   = 49;
  localparam int unsigned DEF_NUM_LEAF_BITS = 3;
  localparam int unsigned DEF_NUM_PORT_BITS = 4;
  localparam int unsigned DEF_CREDIT_BITS   = 8;
  localparam int unsigned DEF_CREDIT_INIT   = 64;

  localparam int unsigned SEQ_BITS =
    DEF_PACKET_BITS - 1 - DEF_NUM_LEAF_BITS - DEF_NUM_PORT_BITS - DEF_PAYLOAD_BITS;

  localparam int unsigned SEQ_LSB   = DEF_PAYLOAD_BITS;
  localparam int unsigned PORT_LSB  = SEQ_LSB + SEQ_BITS;
  localparam int unsigned LEAF_LSB  = PORT_LSB + DEF_NUM_PORT_BITS;
  localparam int unsigned VALID_BIT = DEF_PACKET_BITS - 1;

  typedef enum logic {
    IDLE,
    SEND
  } tx_state_t;

endpackage

// File: rtl/leaf_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter. It grants the first requester found at or after
// i_ptr, wrapping from N-1 back to 0.
module rr_arbiter
  import leaf_tx_pkg::*;
#(
  parameter int unsigned N     = DEF_NUM_OUT_PORTS,
  parameter int unsigned IDX_W = 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  always_comb begin
    logic             w_found;
    logic [IDX_W-1:0] w_c;
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_c     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_c = IDX_W'((32'(i_ptr) + k) % N);
      if (!w_found && i_req[w_c]) begin
        w_found    = 1'b1;
        o_gnt[w_c] = 1'b1;
        o_idx      = w_c;
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/leaf_tx_sched.sv
// Credit-based round-robin scheduler from the user output streams onto the single
// leaf->BFT packet path. It sends at most one packet every two cycles.
module leaf_tx_sched
  import leaf_tx_pkg::*;
#(
  parameter int unsigned NUM_OUT_PORTS = DEF_NUM_OUT_PORTS,
  parameter int unsigned PAYLOAD_BITS  = DEF_PAYLOAD_BITS,
  parameter int unsigned PACKET_BITS   = DEF_PACKET_BITS,
  parameter int unsigned NUM_LEAF_BITS = DEF_NUM_LEAF_BITS,
  parameter int unsigned NUM_PORT_BITS = DEF_NUM_PORT_BITS,
  parameter int unsigned CREDIT_BITS   = DEF_CREDIT_BITS,
  parameter int unsigned CREDIT_INIT   = DEF_CREDIT_INIT,
  localparam int unsigned IDX_W = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_user,
  input  logic [NUM_OUT_PORTS-1:0]                vld_user,
  output logic [NUM_OUT_PORTS-1:0]                ack_user,
  input  logic                                    cfg_wr,
  input  logic [IDX_W-1:0]                        cfg_idx,
  input  logic [NUM_LEAF_BITS-1:0]                cfg_leaf,
  input  logic [NUM_PORT_BITS-1:0]                cfg_port,
  input  logic                                    cfg_en,
  input  logic                                    cred_vld,
  input  logic [IDX_W-1:0]                        cred_idx,
  input  logic [CREDIT_BITS-1:0]                  cred_cnt,
  output logic [PACKET_BITS-1:0]                  pkt_out,
  output logic                                    pkt_vld,
  input  logic                                    pkt_rdy,
  output logic [NUM_OUT_PORTS-1:0]                cred_zero
);

  localparam int unsigned N     = NUM_OUT_PORTS;
  localparam int unsigned SEQ_W = PACKET_BITS - 1 - NUM_LEAF_BITS - NUM_PORT_BITS - PAYLOAD_BITS;

  tx_state_t               r_state, w_state_nxt;
  logic [CREDIT_BITS-1:0]  r_credit [N];
  logic [SEQ_W-1:0]        r_seq    [N];
  logic [NUM_LEAF_BITS-1:0] r_leaf  [N];
  logic [NUM_PORT_BITS-1:0] r_port  [N];
  logic [PAYLOAD_BITS-1:0] w_din_arr [N];
  logic [N-1:0]            r_en, r_ack, r_cred_zero, w_req, w_gnt;
  logic [IDX_W-1:0]        r_rr, w_idx;
  logic                    w_any, w_grant;
  logic [PACKET_BITS-1:0]  r_pkt;

  rr_arbiter #(.N(N), .IDX_W(IDX_W)) u_arb (
    .i_req (w_req),
    .i_ptr (r_rr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_grant = (r_state == IDLE) && w_any;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any)   w_state_nxt = SEND;
      SEND:    if (pkt_rdy) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  for (genvar n = 0; n < N; n++) begin : g_stream
    logic [CREDIT_BITS:0]   w_sum;
    logic [CREDIT_BITS-1:0] w_credit_nxt;

    assign w_din_arr[n] = din_user[n*PAYLOAD_BITS +: PAYLOAD_BITS];
    assign w_req[n]     = vld_user[n] & r_en[n] & (r_credit[n] != '0);

    // Return and consume are summed in one extra bit, so saturation applies to the net result.
    always_comb begin
      w_sum = {1'b0, r_credit[n]};
      if (cred_vld && (cred_idx == IDX_W'(n))) w_sum = w_sum + {1'b0, cred_cnt};
      if (w_grant && w_gnt[n])                 w_sum = w_sum - (CREDIT_BITS+1)'(1);
      w_credit_nxt = w_sum[CREDIT_BITS] ? '1 : w_sum[CREDIT_BITS-1:0];
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        r_credit[n]    <= CREDIT_BITS'(CREDIT_INIT);
        r_cred_zero[n] <= (CREDIT_INIT == 0);
        r_seq[n]       <= '0;
        r_leaf[n]      <= '0;
        r_port[n]      <= '0;
        r_en[n]        <= 1'b0;
      end else begin
        r_credit[n]    <= w_credit_nxt;
        r_cred_zero[n] <= (w_credit_nxt == '0);
        if (w_grant && w_gnt[n]) r_seq[n] <= r_seq[n] + SEQ_W'(1);
        if (cfg_wr && (cfg_idx == IDX_W'(n))) begin
          r_leaf[n] <= cfg_leaf;
          r_port[n] <= cfg_port;
          r_en[n]   <= cfg_en;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ack <= '0;
      r_pkt <= '0;
      r_rr  <= '0;
    end else begin
      r_ack <= w_grant ? w_gnt : '0;
      if (w_grant) begin
        r_pkt <= {1'b1, r_leaf[w_idx], r_port[w_idx], r_seq[w_idx], w_din_arr[w_idx]};
        r_rr  <= (w_idx == IDX_W'(N-1)) ? '0 : w_idx + IDX_W'(1);
      end
    end
  end

  assign ack_user  = r_ack;
  assign pkt_out   = r_pkt;
  assign pkt_vld   = (r_state == SEND);
  assign cred_zero = r_cred_zero;

endmodule

// File: tb/tb_leaf_tx_sched.sv
// Self-checking bench for leaf_tx_sched: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_leaf_tx_sched;
  import leaf_tx_pkg::*;

  localparam int N = 2, PB = 32, PKB = 49, LB = 3, PTB = 4, CB = 8, CI = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [N*PB-1:0] din_user = '0;
  logic [N-1:0] vld_user = '0, ack_user, cred_zero;
  logic cfg_wr = 1'b0, cfg_en = 1'b0, cred_vld = 1'b0, pkt_rdy = 1'b0, pkt_vld;
  logic [0:0] cfg_idx = '0, cred_idx = '0;
  logic [LB-1:0] cfg_leaf = '0;
  logic [PTB-1:0] cfg_port = '0;
  logic [CB-1:0] cred_cnt = '0;
  logic [PKB-1:0] pkt_out;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  leaf_tx_sched #(
    .NUM_OUT_PORTS(N), .PAYLOAD_BITS(PB), .PACKET_BITS(PKB), .NUM_LEAF_BITS(LB),
    .NUM_PORT_BITS(PTB), .CREDIT_BITS(CB), .CREDIT_INIT(CI)
  ) dut (
    .clk(clk), .reset(reset), .din_user(din_user), .vld_user(vld_user), .ack_user(ack_user),
    .cfg_wr(cfg_wr), .cfg_idx(cfg_idx), .cfg_leaf(cfg_leaf), .cfg_port(cfg_port), .cfg_en(cfg_en),
    .cred_vld(cred_vld), .cred_idx(cred_idx), .cred_cnt(cred_cnt),
    .pkt_out(pkt_out), .pkt_vld(pkt_vld), .pkt_rdy(pkt_rdy), .cred_zero(cred_zero)
  );

  // Reference model state, updated once per clock edge from the pre-edge inputs
  int m_cred[N], m_seq[N], m_leaf[N], m_port[N], m_rr;
  bit m_en[N];
  bit m_busy;
  logic [PKB-1:0] m_pkt;
  logic [N-1:0] m_ack;

  task automatic model_edge();
    int g, c, cand;
    m_ack = '0;
    g = -1;
    if (!reset) begin
      for (int n = 0; n < N; n++) begin
        m_cred[n] = CI; m_seq[n] = 0; m_leaf[n] = 0; m_port[n] = 0; m_en[n] = 0;
      end
      m_rr = 0; m_busy = 0; m_pkt = '0;
      return;
    end
    if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        cand = (m_rr + k) % N;
        if (g < 0 && vld_user[cand] && m_en[cand] && m_cred[cand] > 0) g = cand;
      end
      if (g >= 0) begin
        m_pkt = {1'b1, 3'(m_leaf[g]), 4'(m_port[g]), 9'(m_seq[g]), din_user[g*PB +: PB]};
        m_ack[g] = 1'b1;
        m_seq[g] = (m_seq[g] + 1) % 512;
        m_rr = (g + 1) % N;
        m_busy = 1;
      end
    end else if (pkt_rdy) begin
      m_busy = 0;
    end
    for (int n = 0; n < N; n++) begin
      c = m_cred[n] + ((cred_vld && int'(cred_idx) == n) ? int'(cred_cnt) : 0) - int'(m_ack[n]);
      m_cred[n] = (c > 255) ? 255 : c;
    end
    if (cfg_wr) begin
      m_leaf[cfg_idx] = int'(cfg_leaf);
      m_port[cfg_idx] = int'(cfg_port);
      m_en[cfg_idx]   = cfg_en;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; vld_user = '0; cfg_wr = 1'b0; cred_vld = 1'b0; pkt_rdy = 1'b0;
    step(); step();
    reset = 1'b1;
  endtask

  task automatic cfg_stream(input int idx, input int leaf, input int port, input bit en);
    cfg_idx = 1'(idx); cfg_leaf = 3'(leaf); cfg_port = 4'(port); cfg_en = en; cfg_wr = 1'b1;
    step();
    cfg_wr = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pkt_vld !== 1'b0) begin failures++; $display("FAIL reset_pkt_vld got=%b exp=0", pkt_vld); end
    checks++; if (pkt_out !== '0) begin failures++; $display("FAIL reset_pkt_out got=%h exp=0", pkt_out); end
    checks++; if (ack_user !== '0) begin failures++; $display("FAIL reset_ack got=%b exp=00", ack_user); end
    checks++; if (cred_zero !== '0) begin failures++; $display("FAIL reset_cred_zero got=%b exp=00", cred_zero); end
  endtask

  task automatic test_single();
    logic [PKB-1:0] exp_pkt;
    exp_pkt = {1'b1, 3'd5, 4'd2, 9'd0, 32'hDEADBEEF};
    do_reset();
    cfg_stream(0, 5, 2, 1'b1);
    din_user[31:0] = 32'hDEADBEEF; vld_user = 2'b01; pkt_rdy = 1'b1;
    step();
    checks++; if (pkt_vld !== 1'b1) begin failures++; $display("FAIL single_vld got=%b exp=1", pkt_vld); end
    checks++; if (pkt_out !== exp_pkt) begin failures++; $display("FAIL single_pkt got=%h exp=%h", pkt_out, exp_pkt); end
    checks++; if (ack_user !== 2'b01) begin failures++; $display("FAIL single_ack got=%b exp=01", ack_user); end
    vld_user = 2'b00;
    step();
    checks++; if (ack_user !== 2'b00) begin failures++; $display("FAIL single_ack_pulse got=%b exp=00", ack_user); end
    checks++; if (pkt_vld !== 1'b0) begin failures++; $display("FAIL single_idle got=%b exp=0", pkt_vld); end
  endtask

  task automatic test_alternate();
    int gi = 0;
    do_reset();
    cfg_stream(0, $urandom_range(7), $urandom_range(15), 1'b1);
    cfg_stream(1, $urandom_range(7), $urandom_range(15), 1'b1);
    din_user = {$urandom(), $urandom()}; vld_user = 2'b11; pkt_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      checks++; if (ack_user !== m_ack) begin failures++; $display("FAIL alt_ack cyc=%0d got=%b exp=%b", i, ack_user, m_ack); end
      if (ack_user != '0) begin
        checks++;
        if (ack_user !== 2'(1 << (gi % 2))) begin failures++; $display("FAIL alt_order grant=%0d got=%b exp_stream=%0d", gi, ack_user, gi % 2); end
        checks++;
        if (pkt_out[SEQ_LSB +: SEQ_BITS] !== SEQ_BITS'(gi / 2)) begin
          failures++; $display("FAIL alt_seq grant=%0d got=%0d exp=%0d", gi, pkt_out[SEQ_LSB +: SEQ_BITS], gi / 2);
        end
        checks++; if (pkt_out !== m_pkt) begin failures++; $display("FAIL alt_pkt got=%h exp=%h", pkt_out, m_pkt); end
        if (ack_user[0]) din_user[31:0] = $urandom();
        if (ack_user[1]) din_user[63:32] = $urandom();
        gi++;
      end
    end
    checks++; if (gi != 8) begin failures++; $display("FAIL alt_count got=%0d exp=8", gi); end
  endtask

  task automatic test_credit_exhaust();
    int acks = 0;
    do_reset();
    cfg_stream(0, 1, 3, 1'b1);
    vld_user = 2'b01; pkt_rdy = 1'b1; din_user[31:0] = $urandom();
    for (int i = 0; i < 140; i++) begin
      step();
      if (ack_user[0]) begin acks++; din_user[31:0] = $urandom(); end
    end
    checks++; if (acks != 64) begin failures++; $display("FAIL exhaust_acks got=%0d exp=64", acks); end
    checks++; if (cred_zero[0] !== 1'b1) begin failures++; $display("FAIL exhaust_zero got=%b exp=1", cred_zero[0]); end
    acks = 0;
    cred_vld = 1'b1; cred_idx = 1'b0; cred_cnt = 8'd4;
    step();
    cred_vld = 1'b0;
    if (ack_user[0]) acks++;
    for (int i = 0; i < 30; i++) begin
      step();
      if (ack_user[0]) acks++;
    end
    checks++; if (acks != 4) begin failures++; $display("FAIL refill_acks got=%0d exp=4", acks); end
    checks++; if (cred_zero[0] !== 1'b1) begin failures++; $display("FAIL refill_zero got=%b exp=1", cred_zero[0]); end
  endtask

  task automatic test_backpressure();
    logic [PKB-1:0] held;
    do_reset();
    cfg_stream(0, $urandom_range(7), $urandom_range(15), 1'b1);
    din_user[31:0] = $urandom(); vld_user = 2'b01; pkt_rdy = 1'b0;
    step();
    held = pkt_out;
    checks++; if (ack_user !== 2'b01) begin failures++; $display("FAIL bp_ack got=%b exp=01", ack_user); end
    checks++; if (held !== m_pkt) begin failures++; $display("FAIL bp_pkt got=%h exp=%h", held, m_pkt); end
    din_user[31:0] = $urandom();
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (pkt_out !== held) begin failures++; $display("FAIL bp_stable cyc=%0d got=%h exp=%h", i, pkt_out, held); end
      checks++; if (ack_user !== 2'b00) begin failures++; $display("FAIL bp_noack cyc=%0d got=%b exp=00", i, ack_user); end
      checks++; if (pkt_vld !== 1'b1) begin failures++; $display("FAIL bp_vld cyc=%0d got=%b exp=1", i, pkt_vld); end
    end
    pkt_rdy = 1'b1;
    step();
    checks++; if (pkt_vld !== 1'b0) begin failures++; $display("FAIL bp_accept got=%b exp=0", pkt_vld); end
    step();
    checks++; if (ack_user !== 2'b01) begin failures++; $display("FAIL bp_next_ack got=%b exp=01", ack_user); end
    checks++; if (pkt_out !== m_pkt) begin failures++; $display("FAIL bp_next_pkt got=%h exp=%h", pkt_out, m_pkt); end
  endtask

  task automatic test_saturate();
    int acks;
    do_reset();
    cfg_stream(0, 2, 9, 1'b1);
    pkt_rdy = 1'b1; cred_vld = 1'b1; cred_idx = 1'b0; cred_cnt = 8'd191;
    step();
    vld_user = 2'b01; din_user[31:0] = $urandom(); cred_cnt = 8'd10;
    step();
    cred_vld = 1'b0;
    checks++; if (ack_user !== 2'b01) begin failures++; $display("FAIL sat_first_ack got=%b exp=01", ack_user); end
    acks = 1;
    for (int i = 0; i < 600; i++) begin
      step();
      if (ack_user[0]) begin acks++; din_user[31:0] = $urandom(); end
    end
    checks++; if (acks != 256) begin failures++; $display("FAIL sat_acks got=%0d exp=256", acks); end
    checks++; if (cred_zero[0] !== 1'b1) begin failures++; $display("FAIL sat_zero got=%b exp=1", cred_zero[0]); end
    cred_vld = 1'b1; cred_cnt = 8'd1;
    step();
    checks++; if (ack_user !== 2'b00) begin failures++; $display("FAIL sat_zero_noack got=%b exp=00", ack_user); end
    cred_cnt = 8'd3;
    step();
    cred_vld = 1'b0;
    checks++; if (ack_user !== 2'b01) begin failures++; $display("FAIL sat_one_ack got=%b exp=01", ack_user); end
    acks = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ack_user[0]) acks++;
    end
    checks++; if (acks != 4) begin failures++; $display("FAIL sat_small_acks got=%0d exp=4", acks); end
  endtask

  task automatic test_reset_in_send();
    int acks = 0;
    bit first = 1'b1;
    do_reset();
    cfg_stream(0, 3, 3, 1'b1);
    cfg_stream(1, 4, 4, 1'b1);
    vld_user = 2'b11; pkt_rdy = 1'b0;
    for (int i = 0; i < 6; i++) step();
    checks++; if (pkt_vld !== 1'b1) begin failures++; $display("FAIL rst_send_pre got=%b exp=1", pkt_vld); end
    reset = 1'b0;
    step();
    reset = 1'b1;
    checks++; if (pkt_vld !== 1'b0) begin failures++; $display("FAIL rst_send_vld got=%b exp=0", pkt_vld); end
    checks++; if (pkt_out !== '0) begin failures++; $display("FAIL rst_send_pkt got=%h exp=0", pkt_out); end
    pkt_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (ack_user !== 2'b00) begin failures++; $display("FAIL rst_disabled_ack got=%b exp=00", ack_user); end
    end
    vld_user = 2'b00;
    cfg_stream(0, 3, 3, 1'b1);
    vld_user = 2'b01;
    for (int i = 0; i < 140; i++) begin
      step();
      if (ack_user[0]) begin
        if (first) begin
          checks++;
          if (pkt_out[SEQ_LSB +: SEQ_BITS] !== '0) begin failures++; $display("FAIL rst_seq got=%0d exp=0", pkt_out[SEQ_LSB +: SEQ_BITS]); end
          first = 1'b0;
        end
        acks++;
      end
    end
    checks++; if (acks != 64) begin failures++; $display("FAIL rst_credit_acks got=%0d exp=64", acks); end
  endtask

  task automatic test_random();
    logic [N-1:0] exp_cz;
    do_reset();
    cfg_stream(0, $urandom_range(7), $urandom_range(15), 1'b1);
    cfg_stream(1, $urandom_range(7), $urandom_range(15), 1'b1);
    for (int i = 0; i < 3000; i++) begin
      pkt_rdy  = ($urandom_range(3) != 0);
      cred_vld = ($urandom_range(11) == 0);
      cred_idx = 1'($urandom_range(1));
      cred_cnt = ($urandom_range(5) == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(3));
      cfg_wr   = ($urandom_range(39) == 0);
      cfg_idx  = 1'($urandom_range(1));
      cfg_leaf = 3'($urandom_range(7));
      cfg_port = 4'($urandom_range(15));
      cfg_en   = ($urandom_range(3) != 0);
      step();
      for (int n = 0; n < N; n++) exp_cz[n] = (m_cred[n] == 0);
      checks++; if (ack_user !== m_ack) begin failures++; $display("FAIL rnd_ack cyc=%0d got=%b exp=%b", i, ack_user, m_ack); end
      checks++; if (pkt_vld !== m_busy) begin failures++; $display("FAIL rnd_vld cyc=%0d got=%b exp=%b", i, pkt_vld, m_busy); end
      checks++; if (cred_zero !== exp_cz) begin failures++; $display("FAIL rnd_cred_zero cyc=%0d got=%b exp=%b", i, cred_zero, exp_cz); end
      if (m_busy) begin
        checks++; if (pkt_out !== m_pkt) begin failures++; $display("FAIL rnd_pkt cyc=%0d got=%h exp=%h", i, pkt_out, m_pkt); end
      end
      for (int n = 0; n < N; n++) begin
        if (ack_user[n]) begin
          vld_user[n] = ($urandom_range(1) == 1);
          din_user[n*PB +: PB] = $urandom();
        end else if (!vld_user[n] && $urandom_range(2) == 0) begin
          vld_user[n] = 1'b1;
          din_user[n*PB +: PB] = $urandom();
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_credit_exhaust();
    test_backpressure();
    test_saturate();
    test_reset_in_send();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
